// File: rtl/fractal_sync_mp_cnt_cam.sv
// Multi-port counting CAM: per-line arrival counters with same-cycle merging
// and an ordered valid/ready release of completed signatures.
module fractal_sync_mp_cnt_cam #(
    parameter int SIG_WIDTH = 8,
    parameter int N_PORTS   = 4,
    parameter int N_LINES   = 4,
    parameter int CNT_WIDTH = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [N_PORTS-1:0]                   req_valid_i,
    input  logic [N_PORTS-1:0][SIG_WIDTH-1:0]    req_sig_i,
    input  logic [N_PORTS-1:0][CNT_WIDTH-1:0]    req_tgt_i,
    output logic [N_PORTS-1:0]                   req_ready_o,
    output logic                                 rsp_valid_o,
    output logic [SIG_WIDTH-1:0]                 rsp_sig_o,
    output logic [CNT_WIDTH-1:0]                 rsp_cnt_o,
    input  logic                                 rsp_ready_i,
    output logic [$clog2(N_LINES+1)-1:0]         n_used_o
);
    localparam int LW = (N_LINES > 1) ? $clog2(N_LINES) : 1;
    localparam int SW = CNT_WIDTH + $clog2(N_PORTS + 1);
    localparam int UW = $clog2(N_LINES + 1);
    localparam logic [SW-1:0] CMAX = SW'({CNT_WIDTH{1'b1}});

    typedef enum logic [1:0] {FREE, COUNT, DONE} state_t;

    state_t               state [N_LINES];
    logic [SIG_WIDTH-1:0] sig   [N_LINES];
    logic [CNT_WIDTH-1:0] tgt   [N_LINES];
    logic [CNT_WIDTH-1:0] cnt   [N_LINES];

    logic [N_PORTS-1:0]   hit, hit_done, alloc_ok;
    logic [LW-1:0]        dest [N_PORTS];
    logic                 found;
    logic [N_LINES-1:0]   claimed;
    logic [SIG_WIDTH-1:0] new_sig [N_LINES];
    logic [CNT_WIDTH-1:0] new_tgt [N_LINES];
    logic [SW-1:0]        add     [N_LINES];
    logic [SW-1:0]        sum     [N_LINES];
    logic [CNT_WIDTH-1:0] nxt_cnt [N_LINES];
    logic [UW-1:0]        n_alloc;
    logic                 rel_any, fire;
    logic [LW-1:0]        rel_idx;

    always_comb begin
        hit      = '0;
        hit_done = '0;
        alloc_ok = '0;
        claimed  = '0;
        found    = 1'b0;
        for (int p = 0; p < N_PORTS; p++) dest[p] = '0;
        for (int l = 0; l < N_LINES; l++) begin
            new_sig[l] = '0;
            new_tgt[l] = '0;
        end
        for (int p = 0; p < N_PORTS; p++) begin
            for (int l = N_LINES - 1; l >= 0; l--) begin
                if (req_valid_i[p] && state[l] != FREE && sig[l] == req_sig_i[p]) begin
                    hit[p]      = 1'b1;
                    hit_done[p] = (state[l] == DONE);
                    dest[p]     = LW'(l);
                end
            end
            if (req_valid_i[p] && !hit[p]) begin
                // A lower port already missing with this signature owns the allocation
                found = 1'b0;
                for (int q = 0; q < p; q++) begin
                    if (!found && req_valid_i[q] && !hit[q] && req_sig_i[q] == req_sig_i[p]) begin
                        found       = 1'b1;
                        alloc_ok[p] = alloc_ok[q];
                        dest[p]     = dest[q];
                    end
                end
                if (!found) begin
                    for (int l = N_LINES - 1; l >= 0; l--) begin
                        if (state[l] == FREE && !claimed[l]) begin
                            alloc_ok[p] = 1'b1;
                            dest[p]     = LW'(l);
                        end
                    end
                    if (alloc_ok[p]) begin
                        claimed[dest[p]] = 1'b1;
                        new_sig[dest[p]] = req_sig_i[p];
                        new_tgt[dest[p]] = (req_tgt_i[p] == '0) ? CNT_WIDTH'(1) : req_tgt_i[p];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            req_ready_o[p] = !rst_i && req_valid_i[p] &&
                             (hit[p] ? !hit_done[p] : alloc_ok[p]);
        end
    end

    always_comb begin
        n_alloc = '0;
        for (int l = 0; l < N_LINES; l++) begin
            add[l] = '0;
            for (int p = 0; p < N_PORTS; p++) begin
                if (req_ready_o[p] && dest[p] == LW'(l)) add[l] = add[l] + SW'(1);
            end
            sum[l]     = ((state[l] == FREE) ? '0 : SW'(cnt[l])) + add[l];
            nxt_cnt[l] = (sum[l] > CMAX) ? CMAX[CNT_WIDTH-1:0] : sum[l][CNT_WIDTH-1:0];
            n_alloc    = n_alloc + UW'(claimed[l]);
        end
    end

    always_comb begin
        rel_any = 1'b0;
        rel_idx = '0;
        for (int l = N_LINES - 1; l >= 0; l--) begin
            if (state[l] == DONE) begin
                rel_any = 1'b1;
                rel_idx = LW'(l);
            end
        end
        rsp_valid_o = rel_any;
        rsp_sig_o   = rel_any ? sig[rel_idx] : '0;
        rsp_cnt_o   = rel_any ? cnt[rel_idx] : '0;
        fire        = rel_any && rsp_ready_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int l = 0; l < N_LINES; l++) begin
                state[l] <= FREE;
                sig[l]   <= '0;
                tgt[l]   <= '0;
                cnt[l]   <= '0;
            end
            n_used_o <= '0;
        end else begin
            for (int l = 0; l < N_LINES; l++) begin
                if (fire && rel_idx == LW'(l)) begin
                    state[l] <= FREE;
                    cnt[l]   <= '0;
                end else if (claimed[l]) begin
                    state[l] <= (nxt_cnt[l] >= new_tgt[l]) ? DONE : COUNT;
                    sig[l]   <= new_sig[l];
                    tgt[l]   <= new_tgt[l];
                    cnt[l]   <= nxt_cnt[l];
                end else if (state[l] == COUNT && add[l] != '0) begin
                    cnt[l] <= nxt_cnt[l];
                    if (nxt_cnt[l] >= tgt[l]) state[l] <= DONE;
                end
            end
            n_used_o <= n_used_o + n_alloc - UW'(fire);
        end
    end
endmodule

// File: doc/fractal_sync_mp_cnt_cam.md
# fractal_sync_mp_cnt_cam

Multi-port counting CAM for the fractal synchronization tree. It extends the multi-port signature CAM with per-line arrival counters, per-line target counts, same-cycle merging of identical signatures across ports, and an ordered valid/ready release interface. A line is allocated on the first arrival of a signature and counts arrivals until its target is reached. It then holds the signature until a downstream consumer accepts the release, after which the line is free again.

## Interface
Parameters:
- SIG_WIDTH, 8, signature width in bits
- N_PORTS, 4, number of arrival ports
- N_LINES, 4, number of CAM lines (must be >= 1)
- CNT_WIDTH, 4, width of arrival counter and target

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_valid_i  in  [N_PORTS]  arrival request per port
- req_sig_i  in  [N_PORTS][SIG_WIDTH]  arrival signature per port
- req_tgt_i  in  [N_PORTS][CNT_WIDTH]  required arrival count; sampled only on the allocating request
- req_ready_o  out  [N_PORTS]  arrival accepted this cycle
- rsp_valid_o  out  1  a completed signature is awaiting release
- rsp_sig_o  out  SIG_WIDTH  signature of the lowest-index DONE line
- rsp_cnt_o  out  CNT_WIDTH  final arrival count of that line
- rsp_ready_i  in  1  consumer accepts the release
- n_used_o  out  $clog2(N_LINES+1)  number of non-FREE lines

## Operation
- Per-line state is FREE, COUNT or DONE. Each line also holds sig, tgt and cnt registers.
- Match: a port hits a line when the line is not FREE, req_valid_i is high, and req_sig_i equals the line's sig exactly.
- Hit on a COUNT line: req_ready_o=1. The line's cnt increases by the number of ports hitting it this cycle.
- Hit on a DONE line: req_ready_o=0. The port stalls until the line has been released and re-allocated.
- Miss: ports are scanned in ascending index order.
  - The first missing port with a given signature allocates the lowest-index FREE line not already claimed this cycle. That line loads sig, tgt=max(req_tgt_i,1) and cnt=1.
  - Every higher-index missing port with the same signature in the same cycle merges into that allocation. It gets ready=1 and adds 1 to cnt.
  - If no FREE line remains, the missing port and its mergers get ready=0.
- Completion: if the updated cnt >= tgt, the line enters DONE on the same edge. Otherwise it enters or stays in COUNT. This applies to allocation too, so tgt=1 goes FREE->DONE directly.
- Counter arithmetic: cnt_next = cnt + hits, computed in CNT_WIDTH+$clog2(N_PORTS+1) bits and saturated at 2^CNT_WIDTH-1 before storing.
- Release:
  - rsp_valid_o=1 whenever any line is DONE.
  - rsp_sig_o and rsp_cnt_o come from the lowest-index DONE line.
  - When rsp_valid_o&&rsp_ready_i, that line goes to FREE and clears cnt.
  - rsp_sig_o and rsp_cnt_o stay stable while rsp_valid_o=1 and rsp_ready_i=0, unless a lower-index line completes.
- A line released at an edge is not allocatable in the same cycle.
- n_used_o is a register updated as: +allocations −releases per edge.

## Timing
- Reset (async assert, sync-free deassert):
  - all lines FREE, cnt=0, sig=0, tgt=0
  - rsp_valid_o=0, rsp_sig_o=0, rsp_cnt_o=0, n_used_o=0
  - req_ready_o=0 while rst_i=1
- req_ready_o is combinational from req_valid_i, req_sig_i and line state. The arrival takes effect at the next rising edge.
- Arrival-to-release latency:
  - The arrival that reaches tgt at edge k makes rsp_valid_o=1 in cycle k+1.
  - The release handshake at edge m makes the line FREE in cycle m+1.
  - The line can be re-allocated at edge m+1 at the earliest.
- Reset asserted mid-count discards all lines and any pending release; no release is emitted.
- Simultaneous events on one line at one edge:
  - Release and new arrivals: impossible, because arrivals to DONE lines stall.
  - Completion of line j and release of line i<j: both take effect; rsp moves to j next cycle.

## Test plan
- Basic barrier: N_PORTS=4. Port 0 sends sig 0x12, tgt 3 at cycle 1; port 2 sends 0x12 at cycle 3; port 1 sends 0x12 at cycle 5. Required: ready=1 each time; n_used_o=1 from cycle 2; rsp_valid_o=1 in cycle 6 with rsp_sig_o=0x12, rsp_cnt_o=3. Assert rsp_ready_i in cycle 6 -> rsp_valid_o=0 and n_used_o=0 in cycle 7.
- Merge: all 4 ports present sig 0x55, tgt 4, in one cycle -> all ready=1; exactly one line allocated; DONE next cycle with cnt=4.
- Full CAM: N_LINES=2 and 3 distinct signatures (0x01, 0x02, 0x03) on ports 0-2 in one cycle -> ports 0 and 1 ready=1, port 2 ready=0; n_used_o=2.
- DONE stall: sig 0x20 line is DONE and rsp_ready_i=0; port 1 sends 0x20 -> ready=0 for every cycle until release. Port 1 is then accepted at the edge after release; it allocates a fresh line with cnt=1.
- Release ordering: lines 0 and 2 both DONE (sigs 0xA0, 0xA2). Required: rsp_sig_o=0xA0 first, 0xA2 after the handshake; output held stable across 3 cycles of rsp_ready_i=0.
- Reset mid-operation: assert rst_i for 1 cycle with 2 lines in COUNT -> all outputs 0 immediately. After deassert, the previous signatures allocate new lines with cnt=1.
